// File: rtl/oldland_memory_pkg.sv
// Shared Oldland memory-stage definitions: access widths,
// FSM states and the latched transaction record.
package oldland_memory_pkg;

    localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } mem_state_t;

    typedef struct packed {
        logic [1:0] offset;
        logic [1:0] width;
        logic       load;
        logic [2:0] rd_sel;
        logic       wr_result;
    } mem_txn_t;

endpackage

// File: rtl/oldland_mem_lane.sv
// Little-endian lane steering: byte enables, store replication
// and zero-extended load extraction.
module oldland_mem_lane
    import oldland_memory_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic [31:0] store_val,
    input  logic [31:0] bus_data,
    output logic [3:0]  bytesel,
    output logic [31:0] bus_wr_val,
    output logic [31:0] load_val
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = bus_data[7:0];
        case (offset)
            2'd0: byte_lane = bus_data[7:0];
            2'd1: byte_lane = bus_data[15:8];
            2'd2: byte_lane = bus_data[23:16];
            2'd3: byte_lane = bus_data[31:24];
            default: byte_lane = bus_data[7:0];
        endcase
        half_lane = offset[1] ? bus_data[31:16] : bus_data[15:0];
    end

    // Width 2'b11 falls into the word default.
    always_comb begin
        bytesel    = 4'b1111;
        bus_wr_val = store_val;
        load_val   = bus_data;
        case (width)
            MEM_WIDTH_BYTE: begin
                bytesel    = 4'b0001 << offset;
                bus_wr_val = {4{store_val[7:0]}};
                load_val   = {24'd0, byte_lane};
            end
            MEM_WIDTH_HALF: begin
                bytesel    = offset[1] ? 4'b1100 : 4'b0011;
                bus_wr_val = {2{store_val[15:0]}};
                load_val   = {16'd0, half_lane};
            end
            default: begin
                bytesel    = 4'b1111;
                bus_wr_val = store_val;
                load_val   = bus_data;
            end
        endcase
    end

endmodule

// File: rtl/oldland_memory.sv
// Oldland memory-access stage: bus request/ack FSM with timeout,
// upstream stall and writeback registers.
module oldland_memory
    import oldland_memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_out,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [1:0]  mem_width,
    input  logic [31:0] wr_val,
    input  logic        wr_result,
    input  logic [2:0]  rd_sel,
    output logic [31:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic        d_wr_en,
    output logic [31:0] d_wr_val,
    output logic        d_access,
    input  logic [31:0] d_data,
    input  logic        d_ack,
    output logic [31:0] reg_wr_val,
    output logic        update_rd,
    output logic [2:0]  rd_sel_out,
    output logic        stall,
    output logic        bus_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_t  state;
    mem_txn_t    txn;
    logic [CW-1:0] count;

    logic        mem_req;
    logic        timed_out;
    logic [1:0]  lane_offset;
    logic [1:0]  lane_width;
    logic [3:0]  lane_bytesel;
    logic [31:0] lane_wr_val;
    logic [31:0] lane_load;

    assign mem_req   = mem_load | mem_store;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (state == S_WAIT)
                       && !d_ack && (count == LAST);

    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            if (state == S_IDLE) stall = mem_req;
            else stall = !d_ack && !timed_out;
        end
    end

    // Request lanes come from execute; load lanes from the latched access.
    assign lane_offset = (state == S_IDLE) ? alu_out[1:0] : txn.offset;
    assign lane_width  = (state == S_IDLE) ? mem_width : txn.width;

    oldland_mem_lane u_lane (
        .offset     (lane_offset),
        .width      (lane_width),
        .store_val  (wr_val),
        .bus_data   (d_data),
        .bytesel    (lane_bytesel),
        .bus_wr_val (lane_wr_val),
        .load_val   (lane_load)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            txn        <= '0;
            count      <= '0;
            d_addr     <= '0;
            d_bytesel  <= '0;
            d_wr_en    <= 1'b0;
            d_wr_val   <= '0;
            d_access   <= 1'b0;
            reg_wr_val <= '0;
            update_rd  <= 1'b0;
            rd_sel_out <= '0;
            bus_error  <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        state     <= S_WAIT;
                        count     <= '0;
                        d_access  <= 1'b1;
                        d_addr    <= {alu_out[31:2], 2'b00};
                        d_wr_en   <= mem_store;
                        d_bytesel <= lane_bytesel;
                        d_wr_val  <= lane_wr_val;
                        update_rd <= 1'b0;
                        txn       <= '{offset:    alu_out[1:0],
                                       width:     mem_width,
                                       load:      !mem_store,
                                       rd_sel:    rd_sel,
                                       wr_result: wr_result};
                    end else begin
                        reg_wr_val <= wr_val;
                        update_rd  <= wr_result;
                        rd_sel_out <= rd_sel;
                    end
                end
                S_WAIT: begin
                    if (d_ack) begin
                        state    <= S_IDLE;
                        d_access <= 1'b0;
                        d_wr_en  <= 1'b0;
                        if (txn.load) begin
                            reg_wr_val <= lane_load;
                            update_rd  <= txn.wr_result;
                            rd_sel_out <= txn.rd_sel;
                        end else begin
                            update_rd <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state     <= S_IDLE;
                        d_access  <= 1'b0;
                        d_wr_en   <= 1'b0;
                        bus_error <= 1'b1;
                        update_rd <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oldland_memory.sv
// Bench for oldland_memory: directed scenarios plus random traffic,
// all cycles compared against a transaction-level reference model.
module tb_oldland_memory;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_out;
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_width;
    logic [31:0] wr_val;
    logic        wr_result;
    logic [2:0]  rd_sel;
    logic [31:0] d_addr;
    logic [3:0]  d_bytesel;
    logic        d_wr_en;
    logic [31:0] d_wr_val;
    logic        d_access;
    logic [31:0] d_data;
    logic        d_ack;
    logic [31:0] reg_wr_val;
    logic        update_rd;
    logic [2:0]  rd_sel_out;
    logic        stall;
    logic        bus_error;

    always #5 clk = ~clk;

    oldland_memory #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_out    (alu_out),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_width  (mem_width),
        .wr_val     (wr_val),
        .wr_result  (wr_result),
        .rd_sel     (rd_sel),
        .d_addr     (d_addr),
        .d_bytesel  (d_bytesel),
        .d_wr_en    (d_wr_en),
        .d_wr_val   (d_wr_val),
        .d_access   (d_access),
        .d_data     (d_data),
        .d_ack      (d_ack),
        .reg_wr_val (reg_wr_val),
        .update_rd  (update_rd),
        .rd_sel_out (rd_sel_out),
        .stall      (stall),
        .bus_error  (bus_error)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one pending access record plus expected outputs.
    bit          m_busy = 0;
    int          m_cnt = 0;
    bit          m_load = 0;
    logic [1:0]  m_off = '0;
    logic [1:0]  m_w = '0;
    logic [2:0]  m_rd = '0;
    bit          m_wr = 0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wv = '0;
    logic [31:0] e_rwv = '0;
    logic [3:0]  e_bs = '0;
    logic [2:0]  e_rd = '0;
    bit          e_acc = 0;
    bit          e_we = 0;
    bit          e_upd = 0;
    bit          e_berr = 0;

    function automatic logic [3:0] ref_bytesel(logic [1:0] w, logic [1:0] off);
        if (w == 2'd0) return 4'(1 << int'(off));
        if (w == 2'd1) return 4'(3 << (2 * (int'(off) / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_rep(logic [1:0] w, logic [31:0] v);
        if (w == 2'd0) return (v & 32'hFF) * 32'h0101_0101;
        if (w == 2'd1) return (v & 32'hFFFF) * 32'h0001_0001;
        return v;
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] w, logic [1:0] off,
                                             logic [31:0] d);
        if (w == 2'd0) return (d >> (8 * int'(off))) & 32'hFF;
        if (w == 2'd1) return (d >> (16 * (int'(off) / 2))) & 32'hFFFF;
        return d;
    endfunction

    always @(posedge clk) begin
        e_berr = 0;
        if (!rst_n) begin
            m_busy = 0; m_cnt = 0;
            e_addr = '0; e_wv = '0; e_rwv = '0; e_bs = '0; e_rd = '0;
            e_acc = 0; e_we = 0; e_upd = 0;
        end else if (!m_busy) begin
            if (mem_load || mem_store) begin
                m_busy = 1; m_cnt = 0;
                m_load = !mem_store; m_off = alu_out[1:0]; m_w = mem_width;
                m_rd = rd_sel; m_wr = wr_result;
                e_acc = 1; e_we = mem_store;
                e_addr = alu_out & 32'hFFFF_FFFC;
                e_bs = ref_bytesel(mem_width, alu_out[1:0]);
                e_wv = ref_rep(mem_width, wr_val);
                e_upd = 0;
            end else begin
                e_rwv = wr_val; e_upd = wr_result; e_rd = rd_sel;
            end
        end else if (d_ack) begin
            m_busy = 0; e_acc = 0; e_we = 0;
            if (m_load) begin
                e_rwv = ref_load(m_w, m_off, d_data);
                e_upd = m_wr; e_rd = m_rd;
            end else begin
                e_upd = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == TO) begin
                m_busy = 0; e_acc = 0; e_we = 0; e_berr = 1; e_upd = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic e_stall;
        e_stall = rst_n && (m_busy ? (!d_ack && (m_cnt + 1 != TO))
                                   : (mem_load || mem_store));
        checks++;
        if ({d_addr, d_bytesel, d_wr_en, d_wr_val, d_access, reg_wr_val,
             update_rd, rd_sel_out, stall, bus_error} !==
            {e_addr, e_bs, e_we, e_wv, e_acc, e_rwv,
             e_upd, e_rd, e_stall, e_berr}) begin
            errors++;
            $display("FAIL model t=%0t got addr=%h bs=%b we=%b wv=%h acc=%b rwv=%h upd=%b rd=%0d st=%b be=%b expected addr=%h bs=%b we=%b wv=%h acc=%b rwv=%h upd=%b rd=%0d st=%b be=%b",
                     $time, d_addr, d_bytesel, d_wr_en, d_wr_val, d_access,
                     reg_wr_val, update_rd, rd_sel_out, stall, bus_error,
                     e_addr, e_bs, e_we, e_wv, e_acc, e_rwv, e_upd, e_rd,
                     e_stall, e_berr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic nop();
        alu_out = '0; mem_load = 0; mem_store = 0; mem_width = '0;
        wr_val = '0; wr_result = 0; rd_sel = '0;
    endtask

    initial begin
        int  nstall;
        bit  held;
        rst_n = 0; d_ack = 0; d_data = '0;
        nop();
        tick(); tick();
        chk("reset d_access", 32'(d_access), 0);
        chk("reset reg_wr_val", reg_wr_val, 0);
        chk("reset update_rd", 32'(update_rd), 0);
        rst_n = 1;

        // pass-through
        wr_val = 32'h1234_5678; wr_result = 1; rd_sel = 3'd5;
        #1 chk("pt stall", 32'(stall), 0);
        tick();
        chk("pt reg_wr_val", reg_wr_val, 32'h1234_5678);
        chk("pt update_rd", 32'(update_rd), 1);
        chk("pt rd_sel_out", 32'(rd_sel_out), 5);
        nop();

        // byte load, three wait cycles before the ack
        alu_out = 32'h1003; mem_load = 1; mem_width = 2'd0;
        wr_result = 1; rd_sel = 3'd2; d_data = 32'hAABB_CCDD;
        nstall = 0;
        #1 if (stall) nstall++;
        tick();
        chk("bl d_addr", d_addr, 32'h1000);
        chk("bl d_bytesel", 32'(d_bytesel), 32'h8);
        chk("bl d_access", 32'(d_access), 1);
        repeat (3) begin
            #1 if (stall) nstall++;
            tick();
        end
        d_ack = 1;
        #1 if (stall) nstall++;
        tick();
        d_ack = 0;
        nop();
        chk("bl stall cycles", 32'(nstall), 4);
        chk("bl reg_wr_val", reg_wr_val, 32'h0000_00AA);
        chk("bl update_rd", 32'(update_rd), 1);
        chk("bl rd_sel_out", 32'(rd_sel_out), 2);

        // half store
        alu_out = 32'h2002; mem_store = 1; mem_width = 2'd1;
        wr_val = 32'hFFFF_1234; wr_result = 0;
        tick();
        chk("hs d_bytesel", 32'(d_bytesel), 32'hC);
        chk("hs d_wr_val", d_wr_val, 32'h1234_1234);
        chk("hs d_wr_en", 32'(d_wr_en), 1);
        d_ack = 1;
        tick();
        d_ack = 0;
        nop();
        chk("hs update_rd", 32'(update_rd), 0);
        chk("hs d_access", 32'(d_access), 0);

        // timeout with a later stray ack
        alu_out = 32'h3000; mem_load = 1; mem_width = 2'd2;
        wr_result = 1; rd_sel = 3'd7;
        tick();
        repeat (TO - 1) begin
            #1 chk("to stall held", 32'(stall), 1);
            tick();
        end
        nop();
        #1 chk("to stall drop", 32'(stall), 0);
        tick();
        chk("to bus_error", 32'(bus_error), 1);
        chk("to d_access", 32'(d_access), 0);
        chk("to update_rd", 32'(update_rd), 0);
        d_ack = 1;
        tick();
        d_ack = 0;
        chk("to pulse once", 32'(bus_error), 0);
        chk("to stray ack", 32'(d_access), 0);

        // reset during WAIT
        alu_out = 32'h4000; mem_load = 1; mem_width = 2'd2;
        tick();
        chk("rst pre d_access", 32'(d_access), 1);
        rst_n = 0;
        tick();
        chk("rst d_access", 32'(d_access), 0);
        chk("rst d_addr", d_addr, 0);
        chk("rst d_bytesel", 32'(d_bytesel), 0);
        rst_n = 1;
        nop();
        d_ack = 1;
        tick();
        d_ack = 0;
        chk("rst late ack", 32'(d_access), 0);

        // ack in the timeout cycle wins
        alu_out = 32'h5001; mem_load = 1; mem_width = 2'd0;
        wr_result = 1; rd_sel = 3'd3; d_data = 32'h1122_3344;
        tick();
        repeat (TO - 1) tick();
        d_ack = 1;
        #1 chk("ap stall", 32'(stall), 0);
        tick();
        d_ack = 0;
        nop();
        chk("ap bus_error", 32'(bus_error), 0);
        chk("ap reg_wr_val", reg_wr_val, 32'h0000_0033);
        chk("ap update_rd", 32'(update_rd), 1);
        chk("ap rd_sel_out", 32'(rd_sel_out), 3);

        // random traffic
        held = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rst_n = ($urandom_range(0, 99) != 0);
            if (!held) begin
                int kind;
                kind = $urandom_range(0, 9);
                alu_out = $urandom; wr_val = $urandom;
                mem_width = 2'($urandom_range(0, 3));
                wr_result = 1'($urandom_range(0, 1));
                rd_sel = 3'($urandom_range(0, 7));
                mem_load = (kind >= 4 && kind <= 6) || kind == 9;
                mem_store = (kind >= 7);
            end
            d_ack = m_busy ? ($urandom_range(0, 3) == 0)
                           : ($urandom_range(0, 9) == 0);
            d_data = $urandom;
            #2;
            held = stall;
        end

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
